// File: rtl/viterbi_frame_ctrl.sv
// viterbi_frame_ctrl
// Frame-level sequencer for a 4-state (K=3) hard-decision Viterbi decoder.
// It accepts FRAME_LEN received symbol pairs and strobes the path-metric store
// and the survivor memory once for each accepted pair. It then picks the
// minimum-metric end state and traces back through the survivor memory.
// Finally it streams the decoded bits out oldest-first and re-initialises the
// path metrics for the next frame.
//
// Ports
//   clk, rst_n              clock; asynchronous active-low reset
//   in_valid/in_ready       symbol-pair handshake (ready only while filling)
//   in_sym                  received code pair
//   bmu_sym                 registered copy of the last accepted in_sym
//   pm_init                 one-cycle pulse: path metrics load {0,15,15,15}
//   pmsm_we                 path-metric store write enable
//   pm00..pm11              stored path metrics
//   surv_we, surv_waddr     survivor write strobe and address
//   surv_raddr, surv_rdata  survivor read port (combinational); bit i = state i
//   out_valid/out_ready     decoded-bit handshake
//   out_bit, out_last       decoded bit; out_last marks the final bit of a frame
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN = 8,
  parameter int ADDR_W    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sym,
  output logic [1:0]        bmu_sym,
  output logic              pm_init,
  output logic              pmsm_we,
  input  logic [3:0]        pm00,
  input  logic [3:0]        pm01,
  input  logic [3:0]        pm10,
  input  logic [3:0]        pm11,
  output logic              surv_we,
  output logic [ADDR_W-1:0] surv_waddr,
  output logic [ADDR_W-1:0] surv_raddr,
  input  logic [3:0]        surv_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic              out_last
);

  typedef enum logic [2:0] {IDLE, INIT, FILL, SEL, TB, OUT} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     sym_cnt;
  logic [ADDR_W-1:0]     tb_addr;
  logic [ADDR_W-1:0]     out_idx;
  logic [1:0]            tb_state;
  logic [FRAME_LEN-1:0]  dec_buf;
  logic                  accept;
  logic [1:0]            min_idx;
  logic [3:0]            min_pm;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first; a missing branch
  // would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    pm_init   = 1'b0;
    accept    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: state_d = INIT;
      INIT: begin
        pm_init = 1'b1;
        state_d = FILL;
      end
      FILL: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid && sym_cnt == LAST_ADDR) state_d = SEL;
      end
      SEL:  state_d = TB;
      TB:   if (tb_addr == '0) state_d = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready && out_idx == LAST_ADDR) state_d = INIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Minimum-metric end state; strict '<' keeps the lowest index on ties.
  always_comb begin
    min_idx = 2'd0;
    min_pm  = pm00;
    if (pm01 < min_pm) begin min_idx = 2'd1; min_pm = pm01; end
    if (pm10 < min_pm) begin min_idx = 2'd2; min_pm = pm10; end
    if (pm11 < min_pm) begin min_idx = 2'd3; min_pm = pm11; end
  end

  // NOTE: the decoded-bit buffer is a few flops, not a RAM, so it is reset
  // with the rest of the datapath and a reset mid-frame leaves no stale bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_cnt  <= '0;
      tb_addr  <= '0;
      out_idx  <= '0;
      tb_state <= 2'd0;
      dec_buf  <= '0;
      bmu_sym  <= 2'd0;
    end else begin
      case (state_q)
        INIT: sym_cnt <= '0;
        FILL: if (accept) begin
          sym_cnt <= sym_cnt + 1'b1;
          bmu_sym <= in_sym;
        end
        SEL: begin
          tb_state <= min_idx;
          tb_addr  <= LAST_ADDR;
        end
        TB: begin
          // The state MSB is the input bit that led into it; the decision
          // bit names the predecessor's shifted-out bit.
          dec_buf[tb_addr] <= tb_state[1];
          tb_state         <= {tb_state[0], surv_rdata[tb_state]};
          if (tb_addr != '0) tb_addr <= tb_addr - 1'b1;
          else               out_idx <= '0;
        end
        OUT: if (out_ready) out_idx <= out_idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign pmsm_we    = accept;
  assign surv_we    = accept;
  assign surv_waddr = sym_cnt;
  assign surv_raddr = tb_addr;
  assign out_bit    = out_valid & dec_buf[out_idx];
  assign out_last   = out_valid & (out_idx == LAST_ADDR);

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Self-checking bench for viterbi_frame_ctrl (FRAME_LEN=8). The bench acts as
// the survivor memory and the path-metric store. Expected decoded bits come
// from a traceback model computed directly from the frame's metrics and
// decision table.
module tb_viterbi_frame_ctrl;

  localparam int FRAME_LEN = 8;
  localparam int ADDR_W    = 3;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_sym;
  logic [1:0]        bmu_sym;
  logic              pm_init;
  logic              pmsm_we;
  logic [3:0]        pm_v [4];
  logic              surv_we;
  logic [ADDR_W-1:0] surv_waddr;
  logic [ADDR_W-1:0] surv_raddr;
  logic [3:0]        surv_rdata;
  logic              out_valid;
  logic              out_ready;
  logic              out_bit;
  logic              out_last;

  logic [3:0]        surv_mem [FRAME_LEN];

  int total = 0;
  int bad   = 0;

  viterbi_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sym     (in_sym),
    .bmu_sym    (bmu_sym),
    .pm_init    (pm_init),
    .pmsm_we    (pmsm_we),
    .pm00       (pm_v[0]),
    .pm01       (pm_v[1]),
    .pm10       (pm_v[2]),
    .pm11       (pm_v[3]),
    .surv_we    (surv_we),
    .surv_waddr (surv_waddr),
    .surv_raddr (surv_raddr),
    .surv_rdata (surv_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_last   (out_last)
  );

  assign surv_rdata = surv_mem[surv_raddr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Traceback from the rules: start at the lowest-index minimum metric; the
  // decoded bit at step t is the state's MSB; the predecessor is the state
  // shifted left with the stored decision bit appended.
  task automatic model_frame(output logic [FRAME_LEN-1:0] bits);
    int best;
    int s;
    best = 0;
    for (int i = 1; i < 4; i++) if (pm_v[i] < pm_v[best]) best = i;
    s = best;
    for (int t = FRAME_LEN - 1; t >= 0; t--) begin
      bits[t] = ((s >> 1) & 1) != 0;
      s = ((s * 2) % 4) + int'(surv_mem[t][s]);
    end
  endtask

  task automatic set_frame(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d,
                           input bit rand_dec);
    pm_v[0] = a; pm_v[1] = b; pm_v[2] = c; pm_v[3] = d;
    for (int i = 0; i < FRAME_LEN; i++)
      surv_mem[i] = rand_dec ? 4'($urandom_range(0, 15)) : 4'd0;
  endtask

  task automatic set_random_frame();
    set_frame(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_in_ready",   in_ready,   0);
    check("rst_pm_init",    pm_init,    0);
    check("rst_pmsm_we",    pmsm_we,    0);
    check("rst_surv_we",    surv_we,    0);
    check("rst_surv_waddr", surv_waddr, 0);
    check("rst_surv_raddr", surv_raddr, 0);
    check("rst_bmu_sym",    bmu_sym,    0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_bit",    out_bit,    0);
    check("rst_out_last",   out_last,   0);
    adv();
    rst_n = 1'b1;
    settle();
    check("idle_in_ready", in_ready, 0);
    check("idle_pm_init",  pm_init,  0);
    adv();
  endtask

  // Runs one frame starting in the INIT cycle. A non-negative abort_fill or
  // abort_out returns early after that many accepted symbols / output bits.
  task automatic run_frame(input bit gaps, input int mode,
                           input int abort_fill, input int abort_out);
    logic [FRAME_LEN-1:0] exp_bits;
    logic [1:0]           sym;
    int cnt;
    int idx;
    int cyc;

    in_valid  = 1'b1;
    out_ready = 1'b1;
    settle();
    check("init_pm_init",  pm_init,   1);
    check("init_in_ready", in_ready,  0);
    check("init_pmsm_we",  pmsm_we,   0);
    check("init_out_valid", out_valid, 0);
    adv();

    cnt = 0;
    cyc = 0;
    while (cnt < FRAME_LEN && cyc < 200) begin
      if (cnt == abort_fill) return;
      in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      sym       = 2'($urandom_range(0, 3));
      in_sym    = sym;
      out_ready = 1'($urandom_range(0, 1));
      settle();
      check("fill_in_ready",  in_ready,  1);
      check("fill_pm_init",   pm_init,   0);
      check("fill_out_valid", out_valid, 0);
      check("fill_pmsm_we",   pmsm_we,   in_valid);
      check("fill_surv_we",   surv_we,   in_valid);
      if (in_valid) check("fill_surv_waddr", surv_waddr, cnt);
      adv();
      if (in_valid) begin
        check("fill_bmu_sym", bmu_sym, sym);
        cnt++;
      end
      cyc++;
    end
    check("fill_accept_count", cnt, FRAME_LEN);

    in_valid = 1'b1;
    settle();
    check("sel_in_ready",  in_ready,  0);
    check("sel_pmsm_we",   pmsm_we,   0);
    check("sel_surv_we",   surv_we,   0);
    check("sel_out_valid", out_valid, 0);
    adv();

    for (int i = 0; i < FRAME_LEN; i++) begin
      settle();
      check("tb_surv_raddr", surv_raddr, FRAME_LEN - 1 - i);
      check("tb_in_ready",   in_ready,   0);
      check("tb_surv_we",    surv_we,    0);
      check("tb_out_valid",  out_valid,  0);
      adv();
    end

    model_frame(exp_bits);
    idx = 0;
    cyc = 0;
    while (idx < FRAME_LEN && cyc < 300) begin
      if (idx == abort_out) return;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      in_valid = 1'($urandom_range(0, 1));
      settle();
      check("out_valid",    out_valid, 1);
      check("out_in_ready", in_ready,  0);
      check("out_pmsm_we",  pmsm_we,   0);
      check("out_bit",      out_bit,   exp_bits[idx]);
      check("out_last",     out_last,  (idx == FRAME_LEN - 1));
      adv();
      if (out_ready) idx++;
      cyc++;
    end
    check("out_bit_count", idx, FRAME_LEN);
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    in_sym    = 2'd0;
    out_ready = 1'b0;
    set_frame(4'd0, 4'd15, 4'd15, 4'd15, 1'b0);
    #2;
    do_reset();

    // Initial metrics winning, all-zero decisions: all-zero output.
    run_frame(1'b0, 0, -1, -1);

    // State 11 wins: the two newest bits decode as 1.
    set_frame(4'd9, 4'd9, 4'd9, 4'd3, 1'b0);
    run_frame(1'b0, 0, -1, -1);

    // Tie between 01 and 10: state 01 must be chosen.
    set_frame(4'd5, 4'd2, 4'd2, 4'd7, 1'b0);
    run_frame(1'b0, 0, -1, -1);

    // Output back-pressure 1,0,0,... with random decisions.
    set_random_frame();
    run_frame(1'b0, 1, -1, -1);

    // Random frames with input gaps and random output stalls.
    for (int f = 0; f < 4; f++) begin
      set_random_frame();
      run_frame(1'b1, 2, -1, -1);
    end

    // Reset after three accepts, then a clean frame from address 0.
    set_random_frame();
    run_frame(1'b0, 0, 3, -1);
    do_reset();
    set_random_frame();
    run_frame(1'b0, 0, -1, -1);

    // Reset after three output bits, then a gapped frame.
    set_random_frame();
    run_frame(1'b0, 0, -1, 3);
    do_reset();
    set_random_frame();
    run_frame(1'b1, 2, -1, -1);

    settle();
    check("final_init_pulse", pm_init, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
